// File: rtl/alu_seq.sv
// ============================================================================
// Module   : alu_seq
// Brief    : Handshaked ALU with registered single-cycle ops and iterative
//            unsigned multiply / divide / remainder (one bit per cycle).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq #(
   parameter int          WIDTH       = 32,
   parameter logic [31:0] ILLEGAL_VAL = 32'h3141_5926
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       ctrl,
   input  logic [WIDTH-1:0] in_A,
   input  logic [WIDTH-1:0] in_B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             err
);

   localparam int               LW        = $clog2(WIDTH);
   localparam logic [1:0]       c_IDLE    = 2'd0;
   localparam logic [1:0]       c_BUSY    = 2'd1;
   localparam logic [1:0]       c_DONE    = 2'd2;
   localparam logic [3:0]       c_MULU    = 4'd8;
   localparam logic [3:0]       c_DIVU    = 4'd9;
   localparam logic [3:0]       c_REMU    = 4'd10;
   localparam logic [LW-1:0]    c_LAST    = LW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] c_ILLEGAL = WIDTH'(ILLEGAL_VAL);

   logic [1:0]       state_q, state_d;
   logic [LW-1:0]    count_q, count_d;
   logic [3:0]       op_q, op_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             err_q, err_d;

   logic             w_accept;
   logic             w_iterative;
   logic [LW-1:0]    w_shamt;
   logic [WIDTH-1:0] w_simple;
   logic [WIDTH-1:0] w_mul_acc;
   logic [WIDTH:0]   w_trial;
   logic             w_ge;
   logic [WIDTH-1:0] w_div_rem;
   logic [WIDTH-1:0] w_div_quot;

   assign w_accept    = in_valid && in_ready;
   assign w_iterative = (ctrl == c_MULU) || (ctrl == c_DIVU) || (ctrl == c_REMU);
   assign w_shamt     = in_B[LW-1:0];

   always_comb begin
      w_simple = c_ILLEGAL;
      case (ctrl)
         4'd0: w_simple = in_A + in_B;
         4'd1: w_simple = {{(WIDTH-1){1'b0}}, (in_A < in_B)};
         4'd2: w_simple = in_A << w_shamt;
         4'd3: w_simple = in_A >> w_shamt;
         4'd4: w_simple = $signed(in_A) >>> w_shamt;
         4'd5: w_simple = in_A & in_B;
         4'd6: w_simple = in_A | in_B;
         4'd7: w_simple = in_A ^ in_B;
         default: w_simple = c_ILLEGAL;
      endcase
   end

   // Multiply: acc accumulates x (shifting left) under y's LSB (shifting right).
   // Divide: acc is the partial remainder, x shifts the dividend out and the quotient in.
   assign w_mul_acc  = acc_q + (y_q[0] ? x_q : {WIDTH{1'b0}});
   assign w_trial    = {acc_q, x_q[WIDTH-1]};
   assign w_ge       = (w_trial >= {1'b0, y_q});
   assign w_div_rem  = w_ge ? (w_trial[WIDTH-1:0] - y_q) : w_trial[WIDTH-1:0];
   assign w_div_quot = {x_q[WIDTH-2:0], w_ge};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= c_IDLE;
         count_q <= '0;
         op_q    <= '0;
         acc_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         out_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         op_q    <= op_d;
         acc_q   <= acc_d;
         x_q     <= x_d;
         y_q     <= y_d;
         out_q   <= out_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         c_IDLE:  if (w_accept) state_d = w_iterative ? c_BUSY : c_DONE;
         c_BUSY:  if (count_q == c_LAST) state_d = c_DONE;
         c_DONE:  if (out_ready) state_d = c_IDLE;
         default: state_d = c_IDLE;
      endcase
   end

   always_comb begin
      count_d = count_q;
      op_d    = op_q;
      acc_d   = acc_q;
      x_d     = x_q;
      y_d     = y_q;
      out_d   = out_q;
      err_d   = err_q;
      if (state_q == c_IDLE && w_accept) begin
         op_d    = ctrl;
         count_d = '0;
         if (w_iterative) begin
            acc_d = '0;
            x_d   = in_A;
            y_d   = in_B;
         end else begin
            out_d = w_simple;
            err_d = (ctrl > c_REMU);
         end
      end else if (state_q == c_BUSY) begin
         count_d = count_q + 1'b1;
         if (op_q == c_MULU) begin
            acc_d = w_mul_acc;
            x_d   = x_q << 1;
            y_d   = y_q >> 1;
         end else begin
            acc_d = w_div_rem;
            x_d   = w_div_quot;
         end
         if (count_q == c_LAST) begin
            err_d = 1'b0;
            if (op_q == c_MULU)      out_d = w_mul_acc;
            else if (op_q == c_DIVU) out_d = w_div_quot;
            else                     out_d = w_div_rem;
         end
      end
   end

   always_comb begin
      in_ready  = (state_q == c_IDLE);
      out_valid = (state_q == c_DONE);
      out       = out_q;
      err       = err_q;
   end

endmodule

`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the datapath's combinational 8-op ALU.
- Keeps the eight single-cycle ops and registers their result.
- Adds iterative unsigned multiply, divide and remainder, computed one bit per cycle.
- Sits between the issue stage and writeback: accepts one operation at a time over valid/ready and holds the result until writeback takes it.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥ 2 and a power of two.
- ILLEGAL_VAL, 32'h3141_5926, result for undefined ctrl codes (truncated or zero-extended to WIDTH).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request.
- ctrl  input  4  operation code.
- in_A  input  WIDTH  operand A.
- in_B  input  WIDTH  operand B.
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes result.
- out  output  WIDTH  result.
- err  output  1  result came from an illegal ctrl code; qualified by out_valid.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=IDLE, out_valid=0, out=0, err=0, in_ready=1.
  - rst asserted mid-operation aborts the operation; no result is produced.
- Acceptance:
  - A request is accepted on a clock edge where in_valid && in_ready.
  - ctrl, in_A and in_B are captured into internal registers; the inputs are don't-care afterwards.
- in_ready = (state==IDLE). Back-to-back issue is not supported; a new request waits until the previous result is consumed.
- States:
  - IDLE: on accept of ctrl 0-7 or 11-15 → DONE. On accept of ctrl 8-10 → BUSY with count=0.
  - BUSY: one iteration per cycle; count increments. At count==WIDTH-1 the final iteration is performed → DONE.
  - DONE: out_valid=1; out and err are stable. On out_ready → IDLE with out_valid=0 in the next cycle.
- Latency from accept edge to out_valid high:
  - 1 cycle for ctrl 0-7 and 11-15.
  - WIDTH+1 cycles for ctrl 8-10.
  - out_valid may be held indefinitely by out_ready=0.
- Ops (shamt = in_B[$clog2(WIDTH)-1:0]; all arithmetic mod 2^WIDTH):
  - 0 ADD: A+B, carry dropped.
  - 1 SLTU: unsigned A<B, giving 1 or 0, zero-extended.
  - 2 SLL: A<<shamt.
  - 3 SRL: logical A>>shamt.
  - 4 SRA: arithmetic A>>>shamt; A is treated as signed.
  - 5 AND; 6 OR; 7 XOR.
  - 8 MULU: low WIDTH bits of A*B, by shift-add, LSB of B first.
  - 9 DIVU: unsigned A/B, restoring division, MSB first.
  - 10 REMU: unsigned A%B, same datapath as DIVU.
  - 11-15: out=ILLEGAL_VAL, err=1.
- err=0 for ctrl 0-10.
- Divide by zero (B==0): still takes WIDTH+1 cycles.
  - DIVU gives all-ones; REMU gives A; err=0.
- Overflow on ADD and MULU is silent.
- out is not updated outside DONE entry: it holds its last value in IDLE/BUSY. Only out_valid qualifies it.

Test Plan:
- Reset and ADD: reset, WIDTH=32, then ADD with A=32'hFFFF_FFFF, B=2 → 1 cycle later out_valid=1, out=1, err=0. Hold out_ready=0 for 5 cycles → out stable, in_ready=0.
- Shift and compare ops: SRA A=32'h8000_0000, B=32'h0000_0021 (shamt=1) → 32'hC000_0000. SRL with the same operands → 32'h4000_0000. SLTU A=1, B=32'hFFFF_FFFF → 1.
- MULU: A=32'h0001_0003, B=32'h0000_0005 → out_valid exactly 33 cycles after accept, out=32'h0005_000F. Also A=B=32'hFFFF_FFFF → 1.
- DIVU and REMU: DIVU A=100, B=7 → 14; REMU → 2; each at 33 cycles. With B=0: DIVU → 32'hFFFF_FFFF, REMU A=100 → 100.
- Illegal ctrl: ctrl=13 → out=32'h3141_5926, err=1, 1-cycle latency. With WIDTH=8 and ctrl=4'hF → out=8'h26.
- Reset mid-operation: assert rst during MULU at cycle 10 of BUSY → next cycle state IDLE, out_valid=0, in_ready=1. A following ADD 3+4 → 7 with no stale result appearing.
